fifo_frame_reader: RTL and testbench

FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

---
 rtl/fifo_frame_reader.sv | 162 ++++++++++++++++
 tb/tb_fifo_frame_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_reader.sv
// Frame FIFO reader: pulls 128-bit frames and serializes them as 16-bit words toward the SPI transmitter.
// Latency: first word_valid two cycles after fifo_ready is sampled; words back-to-back while word_ready stays high.
// Backpressure: word_out/word_valid hold while word_ready=0; abort drops the frame unpopped.
// Optional feature: define FRAME_HEADER_EN to prefix each frame with the header word {8'hA5, frame_cnt}.
module fifo_frame_reader (
  input  logic         read_clk,
  input  logic         reset_n,
  input  logic         fifo_ready,
  input  logic [127:0] frame_data_out,
  output logic         frame_pop,
  output logic [15:0]  word_out,
  output logic         word_valid,
  input  logic         word_ready,
  input  logic         abort,
  output logic [7:0]   frame_cnt,
  output logic         busy
);

`ifdef FRAME_HEADER_EN
  // Header occupies transfer 0, data words follow at transfers 1..8.
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    POP  = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [127:0]   shadow_q, shadow_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic           hold_q, hold_d;
  logic [15:0]    word_out_q, word_out_d;
  logic           word_valid_q, word_valid_d;
  logic           frame_pop_q, frame_pop_d;

  logic [15:0]    first_word;
  logic [15:0]    next_word;
  logic [2:0]     next_sel;

  // Select the word launched from LOAD and the word following the current index in SEND.
  always_comb begin
`ifdef FRAME_HEADER_EN
    first_word = {8'hA5, frame_cnt_q};
    // Transfer idx+1 carries shadow word idx because transfer 0 is the header.
    next_sel   = idx_q[2:0];
`else
    first_word = frame_data_out[15:0];
    next_sel   = 3'(idx_q + 4'd1);
`endif
    next_word  = shadow_q[{next_sel, 4'b0000} +: 16];
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    frame_cnt_d  = frame_cnt_q;
    hold_d       = hold_q;
    word_out_d   = word_out_q;
    word_valid_d = 1'b0;
    frame_pop_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (fifo_ready && !abort) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          shadow_d     = frame_data_out;
          idx_d        = 4'd0;
          word_out_d   = first_word;
          word_valid_d = 1'b1;
          state_d      = SEND;
        end
      end

      SEND: begin
        if (abort) begin
          // Abort beats a final-word transfer: the frame stays in the FIFO.
          state_d = IDLE;
          idx_d   = 4'd0;
        end else if (word_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d     = POP;
            frame_pop_d = 1'b1;
            idx_d       = 4'd0;
          end else begin
            idx_d        = idx_q + 4'd1;
            word_out_d   = next_word;
            word_valid_d = 1'b1;
          end
        end else begin
          word_valid_d = 1'b1;
        end
      end

      POP: begin
        // Abort is ignored from here on; the pop has already been issued.
        frame_cnt_d = frame_cnt_q + 8'd1;
        hold_d      = 1'b0;
        state_d     = HOLD;
      end

      HOLD: begin
        // Two quiet cycles let the FIFO's synchronized pointers catch up.
        if (hold_q) begin
          hold_d  = 1'b0;
          state_d = IDLE;
        end else begin
          hold_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge read_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      shadow_q     <= '0;
      frame_cnt_q  <= 8'd0;
      hold_q       <= 1'b0;
      word_out_q   <= 16'd0;
      word_valid_q <= 1'b0;
      frame_pop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      frame_cnt_q  <= frame_cnt_d;
      hold_q       <= hold_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      frame_pop_q  <= frame_pop_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign frame_pop  = frame_pop_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: FIFO model feeds numbered frames, scoreboard holds expected words.
// Latency: checks two-cycle start and five-cycle pop-to-next-valid spacing under continuous supply.
// Backpressure: word_ready stall patterns, aborts and mid-frame reset.
module tb_fifo_frame_reader;

`ifdef FRAME_HEADER_EN
  localparam int L = 9;
`else
  localparam int L = 8;
`endif

  logic         read_clk = 1'b0;
  logic         reset_n;
  logic         fifo_ready;
  logic [127:0] frame_data_out;
  logic         frame_pop;
  logic [15:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic         abort;
  logic [7:0]   frame_cnt;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int head_id = 0;
  int tail_id = 0;
  int pops    = 0;
  int xfer_cnt = 0;
  int since_pop = 100;
  bit gap_chk = 1'b0;
  bit prev_hold = 1'b0;
  bit prev_pop  = 1'b0;
  bit prev_vld  = 1'b0;
  logic [15:0] prev_word = 16'd0;
  logic [7:0]  sb_cnt = 8'd0;
  logic [15:0] exp_q[$];

  fifo_frame_reader dut (
    .read_clk       (read_clk),
    .reset_n        (reset_n),
    .fifo_ready     (fifo_ready),
    .frame_data_out (frame_data_out),
    .frame_pop      (frame_pop),
    .word_out       (word_out),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .abort          (abort),
    .frame_cnt      (frame_cnt),
    .busy           (busy)
  );

  always #5 read_clk = ~read_clk;

  // Frame id N carries words {N[11:0], k}; frame 0 is 0x0000..0x0007.
  function automatic logic [127:0] make_frame(input int id);
    logic [127:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) f[16*k +: 16] = {id[11:0], 4'(k)};
    return f;
  endfunction

  assign frame_data_out = make_frame(head_id);
  assign fifo_ready     = (tail_id != head_id);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected first n transfers of frame id, header included when enabled.
  task automatic push_partial(input int id, input int n);
    logic [127:0] f;
    f = make_frame(id);
    for (int t = 0; t < n; t++) begin
`ifdef FRAME_HEADER_EN
      if (t == 0) exp_q.push_back({8'hA5, sb_cnt});
      else        exp_q.push_back(f[16*(t-1) +: 16]);
`else
      exp_q.push_back(f[16*t +: 16]);
`endif
    end
  endtask

  task automatic push_frame(input int id);
    push_partial(id, L);
    sb_cnt = sb_cnt + 8'd1;
  endtask

  // Monitor: scoreboard pop on transfer, stall stability, pop pulse shape and HOLD gap.
  always @(negedge read_clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
      prev_pop  = 1'b0;
      prev_vld  = 1'b0;
      since_pop = 100;
    end else begin
      if (prev_hold) begin
        check_eq("stall_vld", {31'd0, word_valid}, 32'd1);
        check_eq("stall_word", {16'd0, word_out}, {16'd0, prev_word});
      end
      if (frame_pop) begin
        check_eq("pop_single", {31'd0, prev_pop}, 32'd0);
        check_eq("pop_nonempty", 32'(tail_id - head_id > 0), 32'd1);
        if (tail_id != head_id) head_id++;
        pops++;
        since_pop = 0;
      end else begin
        if (since_pop < 100) since_pop++;
        if (since_pop == 1 || since_pop == 2)
          check_eq("hold_vld", {31'd0, word_valid}, 32'd0);
      end
      if (gap_chk && word_valid && !prev_vld && since_pop < 100)
        check_eq("pop_gap", 32'(since_pop), 32'd5);
      if (word_valid && word_ready && !abort) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        else check_eq("word", {16'd0, word_out}, {16'd0, exp_q.pop_front()});
        xfer_cnt++;
      end
      prev_hold = word_valid && !word_ready && !abort;
      prev_word = word_out;
      prev_pop  = frame_pop;
      prev_vld  = word_valid;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_vld"}, {31'd0, word_valid}, 32'd0);
    check_eq({tag, "_word"}, {16'd0, word_out}, 32'd0);
    check_eq({tag, "_pop"}, {31'd0, frame_pop}, 32'd0);
    check_eq({tag, "_cnt"}, {24'd0, frame_cnt}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge read_clk);
    #1;
    check_zero_outputs("rst");
    reset_n = 1'b1;
    sb_cnt  = 8'd0;
  endtask

  task automatic wait_pops(input int target, input int budget, input bit stall);
    int k;
    k = 0;
    while (pops < target && k < budget) begin
      @(posedge read_clk);
      #1;
      if (stall) word_ready = (k % 4 == 0) || (k % 4 == 3);
      k++;
    end
    word_ready = 1'b1;
    check_eq("pops_reached", 32'(pops), 32'(target));
  endtask

  task automatic wait_xfers(input int target);
    int k;
    k = 0;
    while (xfer_cnt < target && k < 200) begin
      @(posedge read_clk);
      #1;
      k++;
    end
    check_eq("xfer_reached", 32'(xfer_cnt), 32'(target));
  endtask

  task automatic run_abort(input int after, input int hold);
    wait_xfers(xfer_cnt + after);
    abort = 1'b1;
    repeat (hold) begin
      @(posedge read_clk);
      #1;
    end
    abort = 1'b0;
  endtask

  initial begin
    int p0;
    logic [7:0] c0;
    reset_n    = 1'b0;
    word_ready = 1'b1;
    abort      = 1'b0;
    #1;
    check_zero_outputs("rst_async");
    apply_reset();

    // Basic frame: latency, back-to-back words, single pop.
    @(posedge read_clk);
    #1;
    push_frame(tail_id);
    tail_id++;
    @(posedge read_clk);
    #1;
    check_eq("lat_load_vld", {31'd0, word_valid}, 32'd0);
    check_eq("lat_load_busy", {31'd0, busy}, 32'd1);
    @(posedge read_clk);
    #1;
    check_eq("lat_first_vld", {31'd0, word_valid}, 32'd1);
    for (int i = 0; i < L - 1; i++) begin
      @(posedge read_clk);
      #1;
      check_eq("no_bubble", {31'd0, word_valid}, 32'd1);
    end
    wait_pops(1, 50, 1'b0);
    check_eq("cnt_after_1", {24'd0, frame_cnt}, 32'd1);

    // Stall pattern 1,0,0,1 on word_ready.
    push_frame(tail_id);
    tail_id++;
    wait_pops(pops + 1, 200, 1'b1);
    check_eq("cnt_after_stall", {24'd0, frame_cnt}, 32'd2);

    // Abort after the third transfer: no pop, frame resent from its first word.
    p0 = pops;
    c0 = frame_cnt;
    push_partial(tail_id, 3);
    push_frame(tail_id);
    tail_id++;
    run_abort(3, 1);
    check_eq("abort_vld", {31'd0, word_valid}, 32'd0);
    check_eq("abort_pops", 32'(pops), 32'(p0));
    check_eq("abort_cnt", {24'd0, frame_cnt}, {24'd0, c0});
    wait_pops(p0 + 1, 100, 1'b0);

    // Abort on the edge of the final-word transfer: abort wins.
    p0 = pops;
    push_partial(tail_id, L - 1);
    push_frame(tail_id);
    tail_id++;
    run_abort(L - 1, 1);
    check_eq("abort_last_vld", {31'd0, word_valid}, 32'd0);
    check_eq("abort_last_pops", 32'(pops), 32'(p0));
    wait_pops(p0 + 1, 100, 1'b0);

    // Abort during POP/HOLD is ignored.
    p0 = pops;
    c0 = frame_cnt;
    push_frame(tail_id);
    tail_id++;
    run_abort(L, 3);
    wait_pops(p0 + 1, 50, 1'b0);
    check_eq("abort_pop_cnt", {24'd0, frame_cnt}, {24'd0, c0 + 8'd1});

    // Reset during the sixth transfer: immediate zero outputs, frame resent after release.
    p0 = pops;
    push_partial(tail_id, 5);
    tail_id++;
    wait_xfers(xfer_cnt + 5);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    check_eq("rst_sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("rst_pops", 32'(pops), 32'(p0));
    repeat (2) @(posedge read_clk);
    #1;
    reset_n = 1'b1;
    sb_cnt  = 8'd0;
    push_frame(tail_id - 1);
    wait_pops(p0 + 1, 100, 1'b0);
    check_eq("rst_resend_cnt", {24'd0, frame_cnt}, 32'd1);

    // 300 frames back to back from reset: counter wraps to 44.
    apply_reset();
    p0 = pops;
    gap_chk = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push_frame(tail_id);
      tail_id++;
    end
    wait_pops(p0 + 300, 6000, 1'b0);
    gap_chk = 1'b0;
    check_eq("wrap_cnt", {24'd0, frame_cnt}, 32'd44);
    check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);

    repeat (4) @(posedge read_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
